decode_stage: RTL
=================

# decode_stage

Registered, parametrised MIPS instruction decode stage between the IF/ID and ID/EX boundaries of the pipeline. It accepts one instruction per cycle over a valid/ready handshake and splits it into register-accurate fields. It also produces an extended immediate and a computed jump target, classifies the instruction, and inserts a single bubble on a load-use hazard. Unused fields are driven to zero, never left holding stale values.

## Interface
- `J_OPCODE`, default 6'd2: opcode decoded as jump.
- `JAL_OPCODE`, default 6'd3: opcode decoded as jump-and-link.
- `LW_OPCODE`, default 6'd35: opcode treated as a load for hazard detection.
- `HAZARD_EN`, default 1: 1 enables load-use bubble insertion; 0 disables it (always pass-through).
- `CNT_W`, default 16: width of the stall counter.

- `clk` in 1: clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard held output and current input.
- `in_valid` in 1: instruction/pc valid.
- `in_ready` out 1: stage accepts input this cycle.
- `instruction` in 32: raw instruction word.
- `p_count` in 32: PC of `instruction`.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts bundle.
- `opcode` out 6, `rs` out 5, `rt` out 5, `rd` out 5, `shamt` out 5, `funct` out 6.
- `imm_ext` out 32: extended immediate.
- `jump_target` out 32: absolute jump target.
- `is_rtype`, `is_itype`, `is_jtype`, `is_link`, `is_load` out 1 each.
- `pc_out` out 32: PC of the decoded instruction.
- `stall_count` out CNT_W: number of bubbles inserted, saturating.

## Operation
- Class:
  - opcode 0 → R-type.
  - `J_OPCODE`/`JAL_OPCODE` → J-type; `is_link`=1 for `JAL_OPCODE` only.
  - Anything else → I-type.
  - `is_load`=1 iff opcode==`LW_OPCODE`.
- R-type: `rs`/`rt`/`rd`/`shamt`/`funct` from bits [25:21]/[20:16]/[15:11]/[10:6]/[5:0]; `imm_ext`=0, `jump_target`=0.
- I-type: `rs`, `rt`, `imm_ext` set.
  - Opcodes 12, 13, 14 zero-extend `instruction[15:0]`; all others sign-extend.
  - `rd`, `shamt`, `funct`, `jump_target` = 0.
- J-type: `jump_target` = {pc4[31:28], instruction[25:0], 2'b00}, where pc4 = `p_count`+4 mod 2^32. All register fields and `imm_ext` = 0.
- Source registers read by the incoming instruction:
  - rs for R/I-type.
  - rt for R-type and I-type opcodes 4 (beq), 5 (bne), 43 (sw).
  - None for J-type.
- Hazard: asserted when `HAZARD_EN` && `out_valid` && `is_load` && `in_valid` && a read source equals the held `rt` && held `rt`≠0.
- Handshake:
  - `in_ready` = flush | ((~`out_valid` | `out_ready`) & ~hazard).
  - Accept occurs when `in_valid` && `in_ready` && ~flush.
- On accept: output registers load the decode of `instruction`; `pc_out` ← `p_count`; `out_valid` ← 1.
- If `out_ready` && `out_valid` and no accept: `out_valid` ← 0. A hazard cycle with `out_ready`=1 is such a cycle, and produces the bubble.
- `stall_count` increments (saturating at all-ones) on each cycle where hazard && `out_ready`.
- Priority: reset > flush > accept > drain. Flush sets `out_valid` ← 0 and discards the input. `stall_count` is unaffected by flush.
- While `out_valid` && ~`out_ready`, all outputs hold stable.

## Timing
- Reset: every output register, including `out_valid`, `pc_out` and `stall_count`, is 0 on the cycle after `reset` is sampled high. `in_ready` is 1 during and after reset, since `out_valid`=0.
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle with no hazards.
- Load-use: exactly one bubble cycle (`out_valid`=0). The dependent instruction is accepted on the bubble cycle and appears on the following cycle.
- Reset or flush mid-stall: the held load and the pending bubble are dropped; the next accept proceeds normally.
- `stall_count` at all-ones stays at all-ones.

## Test plan
- R-type: 0x00221820 (add $3,$1,$2) with `p_count`=0x100 → one cycle later `out_valid`=1, opcode 0, rs 1, rt 2, rd 3, funct 0x20, `imm_ext` 0, `is_rtype`=1, `pc_out`=0x100.
- Immediate extension:
  - 0x2021FFFF (addi) → `imm_ext`=0xFFFFFFFF, `rd`=0.
  - 0x3421FFFF (ori) → `imm_ext`=0x0000FFFF.
- Jump: 0x0C000010 (jal) with `p_count`=0xF0000000 → `jump_target`=0xF0000040, `is_link`=1, `is_jtype`=1, `rs`=`rt`=0.
- Load-use: 0x8C220004 (lw $2,4($1)) then 0x00441820 (add $3,$2,$4), `out_ready`=1 → lw out, one cycle `out_valid`=0 with `in_ready`=0 on the lw cycle, then add; `stall_count`=1. Same sequence with `rt`=0, or with `HAZARD_EN`=0 → no bubble.
- Backpressure/flush:
  - Hold `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0.
  - Assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, instruction not emitted.
  - Assert `reset` mid-stall → all outputs 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus for decode_stage.
// master drives instruction/pc and out_ready; slave is the stage.
interface decode_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [31:0]      p_count;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [31:0]      imm_ext;
  logic [31:0]      jump_target;
  logic             is_rtype;
  logic             is_itype;
  logic             is_jtype;
  logic             is_link;
  logic             is_load;
  logic [31:0]      pc_out;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output in_valid, instruction, p_count, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd,
    input  shamt, funct, imm_ext, jump_target,
    input  is_rtype, is_itype, is_jtype, is_link,
    input  is_load, pc_out, stall_count
  );

  modport slave (
    input  in_valid, instruction, p_count, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd,
    output shamt, funct, imm_ext, jump_target,
    output is_rtype, is_itype, is_jtype, is_link,
    output is_load, pc_out, stall_count
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: registered field split, immediate/jump
// generation and single-bubble load-use hazard insertion.
module decode_stage #(
  parameter logic [5:0] J_OPCODE   = 6'd2,
  parameter logic [5:0] JAL_OPCODE = 6'd3,
  parameter logic [5:0] LW_OPCODE  = 6'd35,
  parameter bit         HAZARD_EN  = 1'b1,
  parameter int         CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  decode_stage_if.slave bus
);

  logic [31:0] ins_w;
  logic [5:0]  op_w;
  logic [31:0] pc4_w;
  logic        r_w, j_w, i_w, zx_w;
  logic        rd_rs_w, rd_rt_w, hit_w;
  logic        hazard_w, in_ready_w, accept_w;

  logic [4:0]  rs_d, rt_d, rd_d, sh_d;
  logic [5:0]  fn_d;
  logic [31:0] imm_d, jt_d;

  logic             valid_q, valid_d;
  logic [5:0]       op_q;
  logic [4:0]       rs_q, rt_q, rd_q, sh_q;
  logic [5:0]       fn_q;
  logic [31:0]      imm_q, jt_q, pc_q;
  logic             r_q, i_q, j_q, link_q, load_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ins_w = bus.instruction;
  assign op_w  = ins_w[31:26];
  assign pc4_w = bus.p_count + 32'd4;

  always_comb begin
    r_w  = (op_w == 6'd0);
    j_w  = !r_w && (op_w == J_OPCODE ||
                    op_w == JAL_OPCODE);
    i_w  = !r_w && !j_w;
    zx_w = (op_w == 6'd12) || (op_w == 6'd13) ||
           (op_w == 6'd14);
  end

  always_comb begin
    rs_d  = '0;
    rt_d  = '0;
    rd_d  = '0;
    sh_d  = '0;
    fn_d  = '0;
    imm_d = '0;
    jt_d  = '0;
    unique case (1'b1)
      r_w: begin
        rs_d = ins_w[25:21];
        rt_d = ins_w[20:16];
        rd_d = ins_w[15:11];
        sh_d = ins_w[10:6];
        fn_d = ins_w[5:0];
      end
      j_w: jt_d = {pc4_w[31:28], ins_w[25:0], 2'b00};
      default: begin
        rs_d  = ins_w[25:21];
        rt_d  = ins_w[20:16];
        imm_d = zx_w ? {16'h0, ins_w[15:0]}
                     : {{16{ins_w[15]}}, ins_w[15:0]};
      end
    endcase
  end

  // Stores and branches also read rt; jumps read nothing.
  always_comb begin
    rd_rs_w = r_w | i_w;
    rd_rt_w = r_w | (i_w & ((op_w == 6'd4) ||
                            (op_w == 6'd5) ||
                            (op_w == 6'd43)));
    hit_w   = (rd_rs_w && ins_w[25:21] == rt_q) ||
              (rd_rt_w && ins_w[20:16] == rt_q);
    hazard_w = HAZARD_EN && valid_q && load_q &&
               bus.in_valid && hit_w && (rt_q != 5'd0);
    in_ready_w = flush |
                 ((~valid_q | bus.out_ready) & ~hazard_w);
    accept_w = bus.in_valid & in_ready_w & ~flush;
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)
      valid_d = 1'b0;
    else if (accept_w)
      valid_d = 1'b1;
    else if (bus.out_ready && valid_q)
      valid_d = 1'b0;
    cnt_d = cnt_q;
    if (hazard_w && bus.out_ready && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      sh_q    <= '0;
      fn_q    <= '0;
      imm_q   <= '0;
      jt_q    <= '0;
      pc_q    <= '0;
      r_q     <= 1'b0;
      i_q     <= 1'b0;
      j_q     <= 1'b0;
      link_q  <= 1'b0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept_w) begin
        op_q   <= op_w;
        rs_q   <= rs_d;
        rt_q   <= rt_d;
        rd_q   <= rd_d;
        sh_q   <= sh_d;
        fn_q   <= fn_d;
        imm_q  <= imm_d;
        jt_q   <= jt_d;
        pc_q   <= bus.p_count;
        r_q    <= r_w;
        i_q    <= i_w;
        j_q    <= j_w;
        link_q <= (op_w == JAL_OPCODE) && !r_w;
        load_q <= (op_w == LW_OPCODE);
      end
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = valid_q;
  assign bus.opcode      = op_q;
  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.shamt       = sh_q;
  assign bus.funct       = fn_q;
  assign bus.imm_ext     = imm_q;
  assign bus.jump_target = jt_q;
  assign bus.is_rtype    = r_q;
  assign bus.is_itype    = i_q;
  assign bus.is_jtype    = j_q;
  assign bus.is_link     = link_q;
  assign bus.is_load     = load_q;
  assign bus.pc_out      = pc_q;
  assign bus.stall_count = cnt_q;

endmodule
